// File: rtl/riscv_mstage_lsu.sv
// riscv_mstage_lsu
// Memory-stage load/store unit. It sits behind the E/M pipeline register and
// uses the ALU result as the effective address. It drives a request/grant/response
// doubleword bus, aligns and extends load data, and stalls the pipeline while an
// access is outstanding.
// Optional watchdog: define RISCV_MSTAGE_TIMEOUT_EN to abort accesses that stay
// in REQ/WAIT for TIMEOUT_CYCLES cycles. The abort is reported on o_riscv_mstage_buserr.
module riscv_mstage_lsu #(
    parameter int width          = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             i_riscv_mstage_clk,
    input  logic             i_riscv_mstage_rst,
    input  logic             i_riscv_mstage_valid,
    input  logic             i_riscv_mstage_memread,
    input  logic             i_riscv_mstage_memwrite,
    input  logic [2:0]       i_riscv_mstage_memext,
    input  logic [width-1:0] i_riscv_mstage_aluresult,
    input  logic [width-1:0] i_riscv_mstage_storedata,
    output logic             o_riscv_mstage_req,
    output logic             o_riscv_mstage_we,
    output logic [width-1:0] o_riscv_mstage_addr,
    output logic [width-1:0] o_riscv_mstage_wdata,
    output logic [7:0]       o_riscv_mstage_strb,
    input  logic             i_riscv_mstage_gnt,
    input  logic             i_riscv_mstage_rvalid,
    input  logic [width-1:0] i_riscv_mstage_rdata,
    output logic [width-1:0] o_riscv_mstage_loaddata,
    output logic             o_riscv_mstage_done,
    output logic             o_riscv_mstage_stall,
    output logic             o_riscv_mstage_misaligned,
    output logic             o_riscv_mstage_buserr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state;
    logic               req_q;
    logic               we_q;
    logic [width-1:0]   addr_q;
    logic [width-1:0]   wdata_q;
    logic [7:0]         strb_q;
    logic               done_q;
    logic [width-1:0]   loaddata_q;
    logic [2:0]         off_q;
    logic [2:0]         ext_q;

    logic               memop;
    logic [1:0]         size;
    logic               mis_raw;
    logic [7:0]         strb_n;
    logic [2:0]         ext_n;
    logic [5:0]         sh;
    logic [width-1:0]   rshift;
    logic [width-1:0]   load_ext;
    logic               timeout_hit;

    assign memop = i_riscv_mstage_valid & (i_riscv_mstage_memread | i_riscv_mstage_memwrite);
    assign sh    = {i_riscv_mstage_aluresult[2:0], 3'b000};

    // Decode access size; a load with 111 or a store with bit2 set acts as a doubleword
    always_comb begin
        size  = i_riscv_mstage_memext[1:0];
        ext_n = i_riscv_mstage_memext;
        if (i_riscv_mstage_memread) begin
            if (i_riscv_mstage_memext == 3'b111) begin
                size  = 2'b11;
                ext_n = 3'b011;
            end
        end else if (i_riscv_mstage_memext[2]) begin
            size  = 2'b11;
            ext_n = 3'b011;
        end
    end

    // Natural-alignment check and byte strobes for the decoded size
    always_comb begin
        mis_raw = 1'b0;
        strb_n  = 8'hFF;
        case (size)
            2'b00: begin
                mis_raw = 1'b0;
                strb_n  = 8'h01 << i_riscv_mstage_aluresult[2:0];
            end
            2'b01: begin
                mis_raw = i_riscv_mstage_aluresult[0];
                strb_n  = 8'h03 << i_riscv_mstage_aluresult[2:0];
            end
            2'b10: begin
                mis_raw = |i_riscv_mstage_aluresult[1:0];
                strb_n  = 8'h0F << i_riscv_mstage_aluresult[2:0];
            end
            default: begin
                mis_raw = |i_riscv_mstage_aluresult[2:0];
                strb_n  = 8'hFF;
            end
        endcase
    end

    assign rshift = i_riscv_mstage_rdata >> {off_q, 3'b000};

    // Sign- or zero-extend the lane-shifted read data according to the latched load code
    always_comb begin
        load_ext = rshift;
        case (ext_q)
            3'b000:  load_ext = {{(width-8){rshift[7]}},   rshift[7:0]};
            3'b001:  load_ext = {{(width-16){rshift[15]}}, rshift[15:0]};
            3'b010:  load_ext = {{(width-32){rshift[31]}}, rshift[31:0]};
            3'b100:  load_ext = {{(width-8){1'b0}},        rshift[7:0]};
            3'b101:  load_ext = {{(width-16){1'b0}},       rshift[15:0]};
            3'b110:  load_ext = {{(width-32){1'b0}},       rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

`ifdef RISCV_MSTAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             buserr_q;

    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in the current REQ or WAIT and restarts on every state entry
    always_ff @(posedge i_riscv_mstage_clk or negedge i_riscv_mstage_rst) begin
        if (!i_riscv_mstage_rst) begin
            tmo_cnt <= '0;
        end else if ((state == REQ && !i_riscv_mstage_gnt) || state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign o_riscv_mstage_buserr = buserr_q;
`else
    assign timeout_hit = 1'b0;
    // Without the watchdog an access can never be aborted, so this is constant zero
    assign o_riscv_mstage_buserr = (TIMEOUT_CYCLES < 0);
`endif

    // Access sequencer: latch the request in IDLE, hold it until grant, collect the load data, then report done
    always_ff @(posedge i_riscv_mstage_clk or negedge i_riscv_mstage_rst) begin
        if (!i_riscv_mstage_rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            done_q     <= 1'b0;
            loaddata_q <= '0;
            off_q      <= '0;
            ext_q      <= '0;
`ifdef RISCV_MSTAGE_TIMEOUT_EN
            buserr_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef RISCV_MSTAGE_TIMEOUT_EN
            buserr_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (memop && !mis_raw) begin
                        state   <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= ~i_riscv_mstage_memread;
                        addr_q  <= {i_riscv_mstage_aluresult[width-1:3], 3'b000};
                        wdata_q <= i_riscv_mstage_storedata << sh;
                        strb_q  <= strb_n;
                        off_q   <= i_riscv_mstage_aluresult[2:0];
                        ext_q   <= ext_n;
                    end
                end
                REQ: begin
                    if (i_riscv_mstage_gnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state  <= RESP;
                            done_q <= 1'b1;
                        end else if (i_riscv_mstage_rvalid) begin
                            loaddata_q <= load_ext;
                            state      <= RESP;
                            done_q     <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        req_q  <= 1'b0;
                        state  <= RESP;
                        done_q <= 1'b1;
`ifdef RISCV_MSTAGE_TIMEOUT_EN
                        buserr_q <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (i_riscv_mstage_rvalid) begin
                        loaddata_q <= load_ext;
                        state      <= RESP;
                        done_q     <= 1'b1;
                    end else if (timeout_hit) begin
                        state  <= RESP;
                        done_q <= 1'b1;
`ifdef RISCV_MSTAGE_TIMEOUT_EN
                        buserr_q <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_riscv_mstage_req        = req_q;
    assign o_riscv_mstage_we         = we_q;
    assign o_riscv_mstage_addr       = addr_q;
    assign o_riscv_mstage_wdata      = wdata_q;
    assign o_riscv_mstage_strb       = strb_q;
    assign o_riscv_mstage_done       = done_q;
    assign o_riscv_mstage_loaddata   = loaddata_q;
    assign o_riscv_mstage_misaligned = i_riscv_mstage_rst & memop & mis_raw & (state == IDLE);
    assign o_riscv_mstage_stall      = i_riscv_mstage_rst & memop & ~mis_raw & (state != RESP);

endmodule

// File: tb/tb_riscv_mstage_lsu.sv
// Testbench for riscv_mstage_lsu. Directed and random loads and stores are checked
// against a byte-level reference model of alignment, strobes and extension.
module tb_riscv_mstage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  memext = 3'b000;
    logic [63:0] aluresult = '0;
    logic [63:0] storedata = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [63:0] rdata = '0;

    logic        req, we, done, stall, misaligned, buserr;
    logic [63:0] addr, wdata, loaddata;
    logic [7:0]  strb;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] model_loaddata = '0;

    riscv_mstage_lsu #(.width(64), .TIMEOUT_CYCLES(4)) dut (
        .i_riscv_mstage_clk        (clk),
        .i_riscv_mstage_rst        (rst_n),
        .i_riscv_mstage_valid      (valid),
        .i_riscv_mstage_memread    (memread),
        .i_riscv_mstage_memwrite   (memwrite),
        .i_riscv_mstage_memext     (memext),
        .i_riscv_mstage_aluresult  (aluresult),
        .i_riscv_mstage_storedata  (storedata),
        .o_riscv_mstage_req        (req),
        .o_riscv_mstage_we         (we),
        .o_riscv_mstage_addr       (addr),
        .o_riscv_mstage_wdata      (wdata),
        .o_riscv_mstage_strb       (strb),
        .i_riscv_mstage_gnt        (gnt),
        .i_riscv_mstage_rvalid     (rvalid),
        .i_riscv_mstage_rdata      (rdata),
        .o_riscv_mstage_loaddata   (loaddata),
        .o_riscv_mstage_done       (done),
        .o_riscv_mstage_stall      (stall),
        .o_riscv_mstage_misaligned (misaligned),
        .o_riscv_mstage_buserr     (buserr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes from the load/store kind and the funct3 code
    function automatic int opSize(input bit load, input logic [2:0] ext);
        if (load) return (ext == 3'b111) ? 8 : (1 << ext[1:0]);
        return ext[2] ? 8 : (1 << ext[1:0]);
    endfunction

    // Pick n bytes starting at byte off, then extend them to 64 bits
    function automatic logic [63:0] refLoad(input logic [63:0] rd, input int off, input int n, input bit sext);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sext && n < 8 && v[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    // Present one memory op and act as the bus, checking every cycle until it completes
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] ext,
                                 input logic [63:0] a, input logic [63:0] sdata,
                                 input logic [63:0] rdv, input int gdly, input int rdly);
        bit          load = rd;
        int          n = opSize(load, ext);
        int          off = int'(a[2:0]);
        bit          mis = (off % n) != 0;
        bit          sext = load && !ext[2];
        logic [63:0] exp_strb = ((64'd1 << n) - 64'd1) << off;
        logic [63:0] exp_wdata = sdata << (8*off);
        logic [63:0] exp_addr = a & ~64'h7;
        int          g_cyc = 1 + gdly;
        int          done_cyc = load ? (g_cyc + rdly + 1) : (g_cyc + 1);

        valid = 1'b1; memread = rd; memwrite = wr; memext = ext;
        aluresult = a; storedata = sdata; gnt = 1'b0; rvalid = 1'b0;
        #1;
        if (mis) begin
            checkOutput("misaligned_flag", misaligned, 1);
            checkOutput("misaligned_stall", stall, 0);
            checkOutput("misaligned_req", req, 0);
            nextCycle();
            checkOutput("misaligned_noreq", req, 0);
            checkOutput("misaligned_idle", misaligned, 1);
            valid = 1'b0;
            #1;
            checkOutput("misaligned_clear", misaligned, 0);
            return;
        end
        checkOutput("present_misaligned", misaligned, 0);
        checkOutput("present_stall", stall, 1);
        checkOutput("present_req", req, 0);
        checkOutput("present_done", done, 0);
        for (int c = 1; c <= done_cyc; c++) begin
            nextCycle();
            if (c == done_cyc) begin
                gnt    = 1'($urandom);
                rvalid = 1'($urandom);
            end else begin
                gnt    = (c == g_cyc);
                rvalid = load && (c == g_cyc + rdly);
            end
            rdata = rvalid ? rdv : {$urandom, $urandom};
            #1;
            if (c <= g_cyc) begin
                checkOutput("req_high", req, 1);
                checkOutput("req_we", we, load ? 0 : 1);
                checkOutput("req_addr", addr, exp_addr);
                checkOutput("req_strb", strb, exp_strb);
                if (!load) checkOutput("req_wdata", wdata, exp_wdata);
                checkOutput("req_stall", stall, 1);
                checkOutput("req_done", done, 0);
            end else if (c < done_cyc) begin
                checkOutput("wait_req", req, 0);
                checkOutput("wait_stall", stall, 1);
                checkOutput("wait_done", done, 0);
            end else begin
                if (load) model_loaddata = refLoad(rdv, off, n, sext);
                checkOutput("resp_done", done, 1);
                checkOutput("resp_stall", stall, 0);
                checkOutput("resp_req", req, 0);
                checkOutput("resp_buserr", buserr, 0);
                checkOutput("resp_loaddata", loaddata, model_loaddata);
            end
        end
        nextCycle();
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        #1;
        checkOutput("after_done", done, 0);
        checkOutput("after_stall", stall, 0);
        checkOutput("after_req", req, 0);
        checkOutput("after_loaddata", loaddata, model_loaddata);
    endtask

    initial begin
        // Reset state
        #1;
        checkOutput("reset_req", req, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_addr", addr, 0);
        checkOutput("reset_loaddata", loaddata, 0);
        checkOutput("reset_buserr", buserr, 0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_stall", stall, 0);
        checkOutput("idle_req", req, 0);

        // No live instruction: nothing happens
        memread = 1'b1; aluresult = 64'h3; memext = 3'b011;
        #1;
        checkOutput("novalid_stall", stall, 0);
        checkOutput("novalid_misaligned", misaligned, 0);
        nextCycle();
        checkOutput("novalid_req", req, 0);
        memread = 1'b0;

        // Directed cases
        applyStimulus(0, 1, 3'b011, 64'h1000, 64'h1122334455667788, '0, 0, 0);
        applyStimulus(1, 0, 3'b000, 64'h2003, 64'h0, 64'h0000000080000000, 0, 3);
        checkOutput("lb_value", model_loaddata, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(1, 0, 3'b101, 64'h2006, 64'h0, 64'hBEEF000000000000, 0, 0);
        checkOutput("lhu_value", model_loaddata, 64'h000000000000BEEF);
        applyStimulus(0, 1, 3'b010, 64'h3002, 64'hDEADBEEF, '0, 0, 0);
        applyStimulus(1, 0, 3'b010, 64'h4004, 64'h0, 64'h87654321_00000000, 2, 1);
        applyStimulus(1, 0, 3'b110, 64'h4004, 64'h0, 64'h87654321_00000000, 1, 0);
        applyStimulus(1, 0, 3'b111, 64'h4010, 64'h0, 64'h0123456789ABCDEF, 0, 2);
        applyStimulus(0, 1, 3'b000, 64'h5005, 64'h00000000000000A5, '0, 3, 0);
        applyStimulus(0, 1, 3'b001, 64'h5006, 64'h000000000000C3C3, '0, 1, 0);
        applyStimulus(0, 1, 3'b110, 64'h5008, 64'hCAFEF00DCAFEF00D, '0, 0, 0);
        applyStimulus(1, 1, 3'b001, 64'h600A, 64'h0, 64'h0000_8001_0000_0000, 0, 1);
        applyStimulus(1, 0, 3'b011, 64'h6004, 64'h0, 64'h0, 0, 0);

        // Reset while waiting for read data, then a late rvalid
        valid = 1'b1; memread = 1'b1; memwrite = 1'b0; memext = 3'b011; aluresult = 64'h7008;
        nextCycle();
        gnt = 1'b1;
        nextCycle();
        gnt = 1'b0;
        #1;
        checkOutput("rst_wait_stall", stall, 1);
        checkOutput("rst_wait_req", req, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req", req, 0);
        checkOutput("rst_mid_we", we, 0);
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_stall", stall, 0);
        checkOutput("rst_mid_misaligned", misaligned, 0);
        checkOutput("rst_mid_addr", addr, 0);
        checkOutput("rst_mid_wdata", wdata, 0);
        checkOutput("rst_mid_strb", strb, 0);
        checkOutput("rst_mid_loaddata", loaddata, 0);
        checkOutput("rst_mid_buserr", buserr, 0);
        model_loaddata = '0;
        nextCycle();
        valid = 1'b0; memread = 1'b0;
        rst_n = 1'b1;
        nextCycle();
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        nextCycle();
        rvalid = 1'b0;
        #1;
        checkOutput("late_rvalid_done", done, 0);
        checkOutput("late_rvalid_req", req, 0);
        checkOutput("late_rvalid_loaddata", loaddata, 0);
        applyStimulus(1, 0, 3'b001, 64'h7002, 64'h0, 64'h0000_0000_7FFF_0000, 1, 1);

`ifdef RISCV_MSTAGE_TIMEOUT_EN
        // Grant never arrives: watchdog aborts after four REQ cycles
        valid = 1'b1; memread = 1'b1; memwrite = 1'b0; memext = 3'b011; aluresult = 64'h8000;
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            checkOutput("tmo_req", req, 1);
            checkOutput("tmo_done", done, 0);
        end
        nextCycle();
        checkOutput("tmo_req_drop", req, 0);
        checkOutput("tmo_abort_done", done, 1);
        checkOutput("tmo_abort_buserr", buserr, 1);
        checkOutput("tmo_loaddata", loaddata, model_loaddata);
        valid = 1'b0; memread = 1'b0;
        nextCycle();
        checkOutput("tmo_after_done", done, 0);
        checkOutput("tmo_after_buserr", buserr, 0);
`endif

        // Random ops against the reference model
        for (int k = 0; k < 60; k++) begin
            int          kind = int'($urandom_range(0, 2));
            logic [2:0]  ext = 3'($urandom);
            logic [63:0] a = {$urandom, $urandom};
            int          n = opSize(kind != 1, ext);
            if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
            applyStimulus(kind != 1, kind != 0, ext, a, {$urandom, $urandom},
                          {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
